// File: rtl/collision_pkg.sv
// Shared constants for collision_resolver: FSM encoding, edge indices and
// field offsets inside a 72-bit per-edge statistics vector.
package collision_pkg;

  localparam int STATS_W = 72;

  typedef logic [1:0] state_t;
  typedef logic [1:0] edge_idx_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_EVAL   = 2'd1;
  localparam state_t ST_COMMIT = 2'd2;

  localparam edge_idx_t EDGE_TOP    = 2'd0;
  localparam edge_idx_t EDGE_BOTTOM = 2'd1;
  localparam edge_idx_t EDGE_RIGHT  = 2'd2;
  localparam edge_idx_t EDGE_LEFT   = 2'd3;

  // {max_R,max_G,max_B,min_R,min_G,min_B,avg_R,avg_G,avg_B}, MSB first
  localparam int OFF_MAX_R = 64;
  localparam int OFF_MAX_G = 56;
  localparam int OFF_MAX_B = 48;
  localparam int OFF_MIN_R = 40;
  localparam int OFF_MIN_G = 32;
  localparam int OFF_MIN_B = 24;
  localparam int OFF_AVG_R = 16;
  localparam int OFF_AVG_G = 8;
  localparam int OFF_AVG_B = 0;

  function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[8]) d = {1'b0, b} - {1'b0, a};
    return d[7:0];
  endfunction

endpackage

// File: rtl/color_match.sv
// Combinational wall-colour matcher for one edge statistics vector.
// Optional spread check compiled in with COLLISION_SPREAD_CHECK_EN.
module color_match
  import collision_pkg::*;
#(
  parameter logic [7:0] WALL_R     = 8'd0,
  parameter logic [7:0] WALL_G     = 8'd0,
  parameter logic [7:0] WALL_B     = 8'd255,
  parameter logic [7:0] TOL        = 8'd16,
  parameter logic [7:0] SPREAD_MAX = 8'd32
) (
  input  logic [STATS_W-1:0] stats,
  output logic               hit
);

  logic [7:0] avg_r, avg_g, avg_b;
  logic       avg_ok;

  assign avg_r = stats[OFF_AVG_R +: 8];
  assign avg_g = stats[OFF_AVG_G +: 8];
  assign avg_b = stats[OFF_AVG_B +: 8];

  assign avg_ok = (abs_diff(avg_r, WALL_R) <= TOL) &&
                  (abs_diff(avg_g, WALL_G) <= TOL) &&
                  (abs_diff(avg_b, WALL_B) <= TOL);

`ifdef COLLISION_SPREAD_CHECK_EN
  // max < min means the edge saw no samples, which never counts as wall
  function automatic logic spread_ok(input logic [7:0] mx, input logic [7:0] mn);
    return (mx >= mn) && ((mx - mn) <= SPREAD_MAX);
  endfunction

  assign hit = avg_ok &&
               spread_ok(stats[OFF_MAX_R +: 8], stats[OFF_MIN_R +: 8]) &&
               spread_ok(stats[OFF_MAX_G +: 8], stats[OFF_MIN_G +: 8]) &&
               spread_ok(stats[OFF_MAX_B +: 8], stats[OFF_MIN_B +: 8]);
`else
  logic unused_spread_fields;
  assign unused_spread_fields = ^{stats[STATS_W-1:OFF_MIN_B], SPREAD_MAX};
  assign hit = avg_ok;
`endif

endmodule

// File: rtl/collision_resolver.sv
// Snapshots four edge statistics on frame_end, matches them one per cycle
// against the wall colour and applies per-edge hit hysteresis.
// Optional spread check: define COLLISION_SPREAD_CHECK_EN.
//
// state     | meaning
// ST_IDLE   | waiting for frame_end
// ST_EVAL   | matching snapshot[idx], idx 0..3
// ST_COMMIT | update hit counters, blocked flags, pulse result_valid
module collision_resolver
  import collision_pkg::*;
#(
  parameter logic [7:0] WALL_R     = 8'd0,
  parameter logic [7:0] WALL_G     = 8'd0,
  parameter logic [7:0] WALL_B     = 8'd255,
  parameter logic [7:0] TOL        = 8'd16,
  parameter int         HIT_FRAMES = 2,
  parameter logic [7:0] SPREAD_MAX = 8'd32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_end,
  input  logic [STATS_W-1:0] stats_top,
  input  logic [STATS_W-1:0] stats_bottom,
  input  logic [STATS_W-1:0] stats_right,
  input  logic [STATS_W-1:0] stats_left,
  output logic               blocked_top,
  output logic               blocked_bottom,
  output logic               blocked_right,
  output logic               blocked_left,
  output logic               result_valid,
  output logic               busy,
  output logic               overrun
);

  localparam logic [2:0] HIT_MAX = 3'(HIT_FRAMES);

  state_t             state;
  edge_idx_t          idx;
  logic [STATS_W-1:0] snap [4];
  logic               hit_r [4];
  logic [2:0]         hit_cnt [4];
  logic [2:0]         cnt_next [4];
  logic [3:0]         blocked_r;
  logic               hit;

  color_match #(
    .WALL_R(WALL_R), .WALL_G(WALL_G), .WALL_B(WALL_B),
    .TOL(TOL), .SPREAD_MAX(SPREAD_MAX)
  ) u_match (
    .stats(snap[idx]),
    .hit  (hit)
  );

  // Saturating count on hit, instant clear on miss
  always_comb begin
    for (int e = 0; e < 4; e++) begin
      cnt_next[e] = 3'd0;
      if (hit_r[e]) cnt_next[e] = (hit_cnt[e] == HIT_MAX) ? hit_cnt[e] : hit_cnt[e] + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      idx          <= 2'd0;
      blocked_r    <= 4'd0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
      for (int e = 0; e < 4; e++) begin
        snap[e]    <= '0;
        hit_r[e]   <= 1'b0;
        hit_cnt[e] <= 3'd0;
      end
    end else begin
      result_valid <= 1'b0;
      overrun      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (frame_end) begin
            snap[EDGE_TOP]    <= stats_top;
            snap[EDGE_BOTTOM] <= stats_bottom;
            snap[EDGE_RIGHT]  <= stats_right;
            snap[EDGE_LEFT]   <= stats_left;
            idx               <= 2'd0;
            state             <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (frame_end) overrun <= 1'b1;
          hit_r[idx] <= hit;
          if (idx == EDGE_LEFT) state <= ST_COMMIT;
          else idx <= idx + 2'd1;
        end
        ST_COMMIT: begin
          if (frame_end) overrun <= 1'b1;
          for (int e = 0; e < 4; e++) begin
            hit_cnt[e]   <= cnt_next[e];
            blocked_r[e] <= (cnt_next[e] == HIT_MAX);
          end
          result_valid <= 1'b1;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign blocked_top    = blocked_r[EDGE_TOP];
  assign blocked_bottom = blocked_r[EDGE_BOTTOM];
  assign blocked_right  = blocked_r[EDGE_RIGHT];
  assign blocked_left   = blocked_r[EDGE_LEFT];
  assign busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_collision_resolver.sv
// Directed self-checking bench for collision_resolver (default parameters).
module tb_collision_resolver;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_end;
  logic [71:0] stats_top, stats_bottom, stats_right, stats_left;
  logic        blocked_top, blocked_bottom, blocked_right, blocked_left;
  logic        result_valid, busy, overrun;

  int n_cmp = 0;
  int n_err = 0;
  int rv_seen = 0;
  int ov_seen = 0;

  logic [71:0] floor_s;
  logic [71:0] wall_s;

  collision_resolver dut (
    .clk(clk), .rst(rst), .frame_end(frame_end),
    .stats_top(stats_top), .stats_bottom(stats_bottom),
    .stats_right(stats_right), .stats_left(stats_left),
    .blocked_top(blocked_top), .blocked_bottom(blocked_bottom),
    .blocked_right(blocked_right), .blocked_left(blocked_left),
    .result_valid(result_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (result_valid) rv_seen++;
    if (overrun) ov_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] mk(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    return {r, g, b, r, g, b, r, g, b};
  endfunction

  function automatic logic [3:0] blk();
    return {blocked_top, blocked_bottom, blocked_right, blocked_left};
  endfunction

  // Call just after a falling edge; returns at the falling edge showing result_valid
  task automatic frame(input string tag, input logic [3:0] exp_blk);
    int k;
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) chk({tag, "_busy"}, busy, 1);
    end while (!result_valid && k < 10);
    chk({tag, "_lat"}, k, 5);
    chk({tag, "_blk"}, blk(), exp_blk);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    floor_s = mk(8'd200, 8'd200, 8'd200);
    wall_s  = mk(8'd10, 8'd5, 8'd250);
    rst = 1'b1;
    frame_end = 1'b0;
    stats_top = '0; stats_bottom = '0; stats_right = '0; stats_left = '0;
    repeat (3) @(negedge clk);
    chk("rst_blk", blk(), 4'b0000);
    chk("rst_rv", result_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ov", overrun, 0);
    chk("rst_cnt", dut.hit_cnt[0], 0);
    rst = 1'b0;

    // Two wall frames on top: slow assert
    @(negedge clk);
    stats_top = wall_s; stats_bottom = floor_s; stats_right = floor_s; stats_left = floor_s;
    frame("f1", 4'b0000);
    chk("f1_cnt", dut.hit_cnt[0], 1);
    repeat (4) @(negedge clk);
    frame("f2", 4'b1000);
    chk("f2_cnt", dut.hit_cnt[0], 2);

    // Fast release on a single miss
    @(negedge clk);
    stats_top = mk(8'd128, 8'd128, 8'd128);
    frame("rel", 4'b0000);
    chk("rel_cnt", dut.hit_cnt[0], 0);

    // Tolerance boundary
    @(negedge clk);
    stats_top = mk(8'd0, 8'd0, 8'd239);
    frame("b239a", 4'b0000);
    chk("b239a_cnt", dut.hit_cnt[0], 1);
    @(negedge clk);
    frame("b239b", 4'b1000);
    chk("b239b_cnt", dut.hit_cnt[0], 2);
    @(negedge clk);
    stats_top = mk(8'd0, 8'd0, 8'd238);
    frame("b238", 4'b0000);
    chk("b238_cnt", dut.hit_cnt[0], 0);
    @(negedge clk);
    stats_top = mk(8'd16, 8'd0, 8'd255);
    frame("r16", 4'b0000);
    chk("r16_cnt", dut.hit_cnt[0], 1);
    @(negedge clk);
    stats_top = mk(8'd17, 8'd0, 8'd255);
    frame("r17", 4'b0000);
    chk("r17_cnt", dut.hit_cnt[0], 0);

    // Edge ordering: bottom and left are wall
    @(negedge clk);
    stats_top = floor_s; stats_bottom = mk(8'd0, 8'd0, 8'd255); stats_left = mk(8'd0, 8'd0, 8'd255);
    frame("ord1", 4'b0000);
    @(negedge clk);
    frame("ord2", 4'b0101);
    chk("ord2_cnt_bot", dut.hit_cnt[1], 2);
    // frame_end coincident with result_valid is accepted
    frame("b2b", 4'b0101);
    chk("b2b_cnt_left", dut.hit_cnt[3], 2);
    @(negedge clk);
    stats_bottom = floor_s; stats_left = floor_s;
    frame("clr", 4'b0000);

    // Overrun: second frame_end 2 cycles later is dropped; snapshot isolated
    @(negedge clk);
    rv_seen = 0; ov_seen = 0;
    stats_top = mk(8'd0, 8'd0, 8'd255);
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    @(negedge clk);
    stats_top = floor_s;
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    repeat (12) @(negedge clk);
    chk("ovr_rv_count", rv_seen, 1);
    chk("ovr_ov_count", ov_seen, 1);
    chk("ovr_cnt", dut.hit_cnt[0], 1);
    chk("ovr_blk", blk(), 4'b0000);

    // Reset during EVAL at idx 2
    @(negedge clk);
    stats_top = wall_s;
    frame("pre", 4'b1000);
    @(negedge clk);
    rv_seen = 0;
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstm_idx", dut.idx, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstm_blk", blk(), 4'b0000);
    chk("rstm_busy", busy, 0);
    chk("rstm_cnt", dut.hit_cnt[0], 0);
    repeat (8) @(negedge clk);
    chk("rstm_rv_count", rv_seen, 0);
    frame("post", 4'b0000);
    chk("post_cnt", dut.hit_cnt[0], 1);

    // Spread check
    @(negedge clk);
    stats_top = floor_s;
    frame("sp0", 4'b0000);
    @(negedge clk);
    stats_top = {8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd200, 8'd0, 8'd0, 8'd250};
`ifdef COLLISION_SPREAD_CHECK_EN
    frame("spA", 4'b0000);
    chk("spA_cnt", dut.hit_cnt[0], 0);
`else
    frame("spA", 4'b0000);
    chk("spA_cnt", dut.hit_cnt[0], 1);
`endif
    @(negedge clk);
    stats_top = {8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd230, 8'd0, 8'd0, 8'd250};
`ifdef COLLISION_SPREAD_CHECK_EN
    frame("spB", 4'b0000);
    chk("spB_cnt", dut.hit_cnt[0], 1);
`else
    frame("spB", 4'b1000);
    chk("spB_cnt", dut.hit_cnt[0], 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/collision_resolver.md
Name: collision_resolver

Overview:
- Downstream consumer of the per-edge background statistics block (top/bottom/right/left max/min/avg of R, G, B under the sprite border).
- On each frame_end strobe it snapshots the four edge statistic vectors and evaluates the edges one per cycle against a configured wall colour, using one shared matcher.
- It applies per-edge frame hysteresis and publishes registered blocked_* flags plus a one-cycle result_valid to the sprite movement controller.

Parameters:
- WALL_R, 8'd0: wall colour, red channel.
- WALL_G, 8'd0: wall colour, green channel.
- WALL_B, 8'd255: wall colour, blue channel.
- TOL, 8'd16: maximum allowed |avg - WALL| per channel.
- HIT_FRAMES, 2: consecutive hit frames required before an edge is blocked (range 1..7).
- SPREAD_MAX, 8'd32: maximum (max - min) per channel; used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- frame_end  in  1  one-cycle pulse; statistics for the current frame are final.
- stats_top  in  72  {max_R,max_G,max_B,min_R,min_G,min_B,avg_R,avg_G,avg_B}, MSB first, 8 bits each.
- stats_bottom  in  72  same packing as stats_top.
- stats_right  in  72  same packing as stats_top.
- stats_left  in  72  same packing as stats_top.
- blocked_top  out  1  top edge is blocked.
- blocked_bottom  out  1  bottom edge is blocked.
- blocked_right  out  1  right edge is blocked.
- blocked_left  out  1  left edge is blocked.
- result_valid  out  1  one-cycle pulse; all blocked_* outputs updated this cycle.
- busy  out  1  high whenever state is not IDLE.
- overrun  out  1  one-cycle pulse; a frame_end was dropped.

Behaviour:
- Reset: all outputs 0, all hit counters 0, state IDLE, edge index 0, snapshot registers 0.
- States: IDLE, EVAL, COMMIT.
- IDLE: on frame_end at edge t, register all four stats vectors into the snapshot, set idx=0, go to EVAL.
- EVAL: at each of edges t+1..t+4, compute hit[idx] from the snapshot. Edge order is idx 0=top, 1=bottom, 2=right, 3=left. At idx==3, go to COMMIT; otherwise increment idx.
- COMMIT (edge t+5), per edge:
  - hit: counter increments, saturating at HIT_FRAMES.
  - miss: counter clears to 0.
  - blocked_e <= (next counter == HIT_FRAMES).
  - result_valid <= 1; return to IDLE.
- Latency: result_valid and the updated blocked_* are visible in the cycle after edge t+5, i.e. 5 clocks after frame_end is sampled.
- result_valid is high for exactly one cycle per accepted frame.
- blocked_* hold their value between commits.
- Hit rule: hit when |avg_C - WALL_C| <= TOL for each of C = R, G, B.
  - Absolute difference is computed in 9-bit unsigned and truncated to 8 bits (the result is always <= 255).
  - Comparisons are inclusive.
- A miss clears blocked on that same frame's commit (fast release, slow assert).
- frame_end while busy (EVAL or COMMIT): frame dropped; overrun pulses for 1 cycle in the following cycle; snapshot and state are unaffected.
- frame_end in the cycle result_valid is high: state is already IDLE, so the frame is accepted normally.
- Snapshot isolation: stats_* changes after capture have no effect on the frame under evaluation.
- rst mid-EVAL or mid-COMMIT: immediate return to the reset state; no result_valid for the aborted frame.
- HIT_FRAMES=1: an edge blocks on the first hit frame.

Optional Feature:
- Macro: COLLISION_SPREAD_CHECK_EN.
- Defined: hit additionally requires (max_C - min_C) <= SPREAD_MAX on every channel. This rejects edges that straddle the wall and open floor.
  - If max_C < min_C (no samples taken on that edge), the edge is treated as a miss.
- Undefined: only the avg tolerance rule applies; max/min fields are ignored; SPREAD_MAX is unused; latency is identical.

Decomposition:
- Shared package collision_pkg:
  - State encoding (IDLE, EVAL, COMMIT).
  - Edge index constants (EDGE_TOP=0, EDGE_BOTTOM=1, EDGE_RIGHT=2, EDGE_LEFT=3).
  - Bit offsets of the nine fields inside a 72-bit stats vector.
  - STATS_W=72.
- Sub-module color_match: purely combinational. Takes one 72-bit stats vector, the WALL_*, TOL and SPREAD_MAX parameters; outputs hit. The spread check sits inside it under the same macro. The top level instantiates it once and feeds it the snapshot selected by idx.

Test Plan:
- Defaults (WALL=0,0,255, TOL=16, HIT_FRAMES=2); top avg=(10,5,250), other edges avg=(200,200,200); two frame_end pulses 10 cycles apart -> after frame 1, result_valid at +5 with all blocked 0; after frame 2, blocked_top=1 and the others 0.
- Boundary: top avg_B=239 (diff 16) -> hit; avg_B=238 (diff 17) -> miss. Check the counter in both cases.
- Blocked top, then one frame with top avg=(128,128,128) -> blocked_top=0 at that frame's result_valid.
- frame_end re-pulsed 2 cycles after an accepted one -> overrun pulses once; exactly one result_valid; the second frame's stats are ignored.
- Assert rst at EVAL idx=2 -> no result_valid; all outputs and counters 0; the next frame behaves as the first frame after reset.
- With COLLISION_SPREAD_CHECK_EN: avg=(0,0,250), max_B=255, min_B=200 (spread 55) -> miss; min_B=230 (spread 25) -> hit. Without the macro, both are hits.
